// File: rtl/hamming_trace_collector_if.sv
// Readout stream from the trace collector to the analysis side.
// The master drives data/valid/last and the slave drives ready.
interface hamming_trace_collector_if #(
  parameter int unsigned SAMPLE_W = 4
) ();
  logic [SAMPLE_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/hamming_trace_collector.sv
// Captures a TRACE_LEN-sample Hamming-weight trace, sums it, and streams it out.
// Optional macro HTC_PEAK_TRACK_EN adds peak_val/peak_idx tracking of the largest sample.
module hamming_trace_collector #(
  parameter int unsigned TRACE_LEN = 16,
  parameter int unsigned SAMPLE_W  = 4,
  localparam int unsigned IDX_W    = $clog2(TRACE_LEN),
  localparam int unsigned SUM_W    = SAMPLE_W + IDX_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                busy,
  hamming_trace_collector_if.master stream,
  output logic [SUM_W-1:0]    trace_sum,
  output logic                done
`ifdef HTC_PEAK_TRACK_EN
  ,
  output logic [SAMPLE_W-1:0] peak_val,
  output logic [IDX_W-1:0]    peak_idx
`endif
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TRACE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StDump} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                done_q, done_d;
  logic                accept;
  logic [SAMPLE_W-1:0] mem [TRACE_LEN];

`ifdef HTC_PEAK_TRACK_EN
  logic [SAMPLE_W-1:0] peak_val_q, peak_val_d;
  logic [IDX_W-1:0]    peak_idx_q, peak_idx_d;
`endif

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    sum_d    = sum_q;
    data_d   = data_q;
    done_d   = 1'b0;
    accept   = 1'b0;
`ifdef HTC_PEAK_TRACK_EN
    peak_val_d = peak_val_q;
    peak_idx_d = peak_idx_q;
`endif
    if (abort) begin
      // Abort outranks start, sample and transfer in every state.
      state_d = StIdle;
      sum_d   = '0;
`ifdef HTC_PEAK_TRACK_EN
      peak_val_d = '0;
      peak_idx_d = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d  = StCapture;
            wr_idx_d = '0;
            rd_idx_d = '0;
            sum_d    = '0;
`ifdef HTC_PEAK_TRACK_EN
            peak_val_d = '0;
            peak_idx_d = '0;
`endif
          end
        end
        StCapture: begin
          if (sample_valid) begin
            accept   = 1'b1;
            sum_d    = sum_q + SUM_W'(sample_in);
            wr_idx_d = wr_idx_q + IDX_W'(1);
`ifdef HTC_PEAK_TRACK_EN
            // Strict compare keeps the earliest index on ties.
            if (sample_in > peak_val_q) begin
              peak_val_d = sample_in;
              peak_idx_d = wr_idx_q;
            end
`endif
            if (wr_idx_q == LastIdx) begin
              state_d = StDump;
              // Slot 0 was written on an earlier cycle, so it is safe to preload.
              data_d  = mem[0];
            end
          end
        end
        StDump: begin
          if (stream.out_ready) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            if (rd_idx_q == LastIdx) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              data_d = mem[rd_idx_q + IDX_W'(1)];
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      sum_q    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
`ifdef HTC_PEAK_TRACK_EN
      peak_val_q <= '0;
      peak_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      sum_q    <= sum_d;
      data_q   <= data_d;
      done_q   <= done_d;
`ifdef HTC_PEAK_TRACK_EN
      peak_val_q <= peak_val_d;
      peak_idx_q <= peak_idx_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx_q] <= sample_in;
    end
  end

  assign busy             = (state_q != StIdle);
  assign stream.out_valid = (state_q == StDump);
  assign stream.out_last  = (state_q == StDump) && (rd_idx_q == LastIdx);
  assign stream.out_data  = data_q;
  assign trace_sum        = sum_q;
  assign done             = done_q;

`ifdef HTC_PEAK_TRACK_EN
  assign peak_val = peak_val_q;
  assign peak_idx = peak_idx_q;
`endif

endmodule

// File: tb/tb_hamming_trace_collector.sv
// Bench for hamming_trace_collector at TRACE_LEN=4: vector table, corner sequences, random traces.
// Define HTC_PEAK_TRACK_EN to also check the peak outputs.
module tb_hamming_trace_collector;
  localparam int unsigned TRACE_LEN = 4;
  localparam int unsigned SAMPLE_W  = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned SUM_W     = 7;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                busy;
  logic [SUM_W-1:0]    trace_sum;
  logic                done;
`ifdef HTC_PEAK_TRACK_EN
  logic [SAMPLE_W-1:0] peak_val;
  logic [IDX_W-1:0]    peak_idx;
`endif

  hamming_trace_collector_if #(.SAMPLE_W(SAMPLE_W)) ifc ();

  hamming_trace_collector #(
    .TRACE_LEN(TRACE_LEN),
    .SAMPLE_W (SAMPLE_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .busy        (busy),
    .stream      (ifc),
    .trace_sum   (trace_sum),
    .done        (done)
`ifdef HTC_PEAK_TRACK_EN
    ,
    .peak_val    (peak_val),
    .peak_idx    (peak_idx)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef logic [3:0][3:0] trace_t;

  typedef struct {
    trace_t     s;
    int         gap;
    logic [7:0] ready_pat;
    logic [6:0] exp_sum;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic trace_t pack4(input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] c, input logic [3:0] d);
    trace_t t;
    t[0] = a;
    t[1] = b;
    t[2] = c;
    t[3] = d;
    return t;
  endfunction

`ifdef HTC_PEAK_TRACK_EN
  // Peak = largest value, index = first position holding it.
  task automatic check_peak(input trace_t s);
    logic [3:0] mx;
    int         first;
    mx = 0;
    for (int i = 0; i < 4; i++) mx = (s[i] > mx) ? s[i] : mx;
    first = 0;
    for (int i = 3; i >= 0; i--) if (s[i] == mx) first = i;
    check("peak_val", 32'(peak_val), 32'(mx));
    check("peak_idx", 32'(peak_idx), first);
  endtask
`endif

  // gap < 0 selects a random gap of 0..3 idle cycles before each sample.
  task automatic capture(input trace_t s, input int gap, input logic [6:0] exp_sum);
    start        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 4'hF;
    tick();
    start        = 1'b0;
    sample_valid = 1'b0;
    check("cap_busy", 32'(busy), 1);
    check("cap_sum_clear", 32'(trace_sum), 0);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      for (int j = 0; j < g; j++) begin
        sample_valid = 1'b0;
        sample_in    = 4'($urandom);
        tick();
        check("cap_stall_no_valid", 32'(ifc.out_valid), 0);
        check("cap_stall_busy", 32'(busy), 1);
      end
      sample_valid = 1'b1;
      sample_in    = s[i];
      tick();
      if (i < 3) check("cap_no_early_valid", 32'(ifc.out_valid), 0);
    end
    sample_valid = 1'b0;
    check("dump_entry_valid", 32'(ifc.out_valid), 1);
    check("trace_sum", 32'(trace_sum), 32'(exp_sum));
  endtask

  task automatic dump(input trace_t s, input logic [7:0] pat, input logic [6:0] exp_sum);
    int         k;
    int         cyc;
    logic       stalled;
    logic [3:0] held;
    k       = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (k < 4 && cyc < 64) begin
      logic rdy;
      rdy           = (cyc < 8) ? pat[cyc] : 1'b1;
      ifc.out_ready = rdy;
      sample_valid  = 1'($urandom);
      sample_in     = 4'($urandom);
      check("dump_valid", 32'(ifc.out_valid), 1);
      check("dump_done_low", 32'(done), 0);
      check("dump_last", 32'(ifc.out_last), (k == 3) ? 1 : 0);
      if (stalled) check("dump_hold", 32'(ifc.out_data), 32'(held));
      if (rdy) begin
        check("dump_data", 32'(ifc.out_data), 32'(s[k]));
        k++;
      end
      stalled = !rdy;
      held    = ifc.out_data;
      tick();
      cyc++;
    end
    check("dump_transfer_count", k, 4);
    ifc.out_ready = 1'b0;
    sample_valid  = 1'b0;
    check("done_pulse", 32'(done), 1);
    check("idle_no_valid", 32'(ifc.out_valid), 0);
    check("idle_no_last", 32'(ifc.out_last), 0);
    check("idle_busy", 32'(busy), 0);
    check("sum_held", 32'(trace_sum), 32'(exp_sum));
    tick();
    check("done_single", 32'(done), 0);
    check("sum_held2", 32'(trace_sum), 32'(exp_sum));
  endtask

  task automatic run_vec(input vec_t v);
    capture(v.s, v.gap, v.exp_sum);
`ifdef HTC_PEAK_TRACK_EN
    check_peak(v.s);
`endif
    dump(v.s, v.ready_pat, v.exp_sum);
`ifdef HTC_PEAK_TRACK_EN
    check_peak(v.s);
`endif
  endtask

  initial begin
    rst_n         = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    sample_valid  = 1'b0;
    sample_in     = '0;
    ifc.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(ifc.out_valid), 0);
    check("rst_last", 32'(ifc.out_last), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", 32'(ifc.out_data), 0);
    check("rst_sum", 32'(trace_sum), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("idle_after_rst", 32'(busy), 0);

    vecs[0] = '{s: pack4(3, 0, 8, 5),   gap: 0, ready_pat: 8'hFF, exp_sum: 7'd16};
    vecs[1] = '{s: pack4(1, 2, 3, 4),   gap: 2, ready_pat: 8'hFF, exp_sum: 7'd10};
    vecs[2] = '{s: pack4(9, 1, 15, 6),  gap: 0, ready_pat: 8'hF4, exp_sum: 7'd31};
    vecs[3] = '{s: pack4(15, 15, 15, 15), gap: 1, ready_pat: 8'hAA, exp_sum: 7'd60};
    vecs[4] = '{s: pack4(2, 8, 8, 1),   gap: 0, ready_pat: 8'hFF, exp_sum: 7'd19};
    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Abort after two samples, then a fresh full trace.
    start = 1'b1;
    tick();
    start        = 1'b0;
    sample_valid = 1'b1;
    sample_in    = 4'd7;
    tick();
    tick();
    sample_valid = 1'b0;
    check("abort_pre_sum", 32'(trace_sum), 14);
    abort         = 1'b1;
    ifc.out_ready = 1'b1;
    tick();
    abort         = 1'b0;
    ifc.out_ready = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_sum", 32'(trace_sum), 0);
    check("abort_valid", 32'(ifc.out_valid), 0);
`ifdef HTC_PEAK_TRACK_EN
    check("abort_peak", 32'(peak_val), 0);
`endif
    tick();
    check("abort_no_done", 32'(done), 0);
    run_vec(vecs[0]);

    // Abort during DUMP together with a transfer.
    capture(vecs[2].s, 0, vecs[2].exp_sum);
    ifc.out_ready = 1'b1;
    abort         = 1'b1;
    tick();
    abort         = 1'b0;
    ifc.out_ready = 1'b0;
    check("dabort_valid", 32'(ifc.out_valid), 0);
    check("dabort_last", 32'(ifc.out_last), 0);
    check("dabort_sum", 32'(trace_sum), 0);
    check("dabort_busy", 32'(busy), 0);
    tick();
    check("dabort_no_done", 32'(done), 0);

    // Start with abort in IDLE stays idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(busy), 0);

    // Start pulsed during CAPTURE has no effect.
    start = 1'b1;
    tick();
    sample_valid = 1'b1;
    start        = 1'b0;
    sample_in    = 4'd3;
    tick();
    start     = 1'b1;
    sample_in = 4'd0;
    tick();
    start     = 1'b0;
    sample_in = 4'd8;
    tick();
    sample_in = 4'd5;
    tick();
    sample_valid = 1'b0;
    check("midstart_valid", 32'(ifc.out_valid), 1);
    check("midstart_sum", 32'(trace_sum), 16);
    dump(pack4(3, 0, 8, 5), 8'hFF, 7'd16);

    // Asynchronous reset in the middle of DUMP.
    capture(vecs[3].s, 0, vecs[3].exp_sum);
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_valid", 32'(ifc.out_valid), 0);
    check("mrst_last", 32'(ifc.out_last), 0);
    check("mrst_sum", 32'(trace_sum), 0);
    check("mrst_data", 32'(ifc.out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("mrst_idle", 32'(busy), 0);
    check("mrst_no_done", 32'(done), 0);

    // Random traces against the queue-free reference: trace = accepted samples in order.
    for (int n = 0; n < 20; n++) begin
      trace_t     s;
      logic [6:0] sm;
      sm = '0;
      for (int i = 0; i < 4; i++) begin
        s[i] = 4'($urandom);
        sm   = sm + 7'(s[i]);
      end
      capture(s, -1, sm);
`ifdef HTC_PEAK_TRACK_EN
      check_peak(s);
`endif
      dump(s, 8'($urandom), sm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
